// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage - EXMEM in, MEMWB out, branch resolve + stall out, req/ack dmem bus with timeout, misalign/bus_err flags
module mem_stage #(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] EXMEM_pc_branched_i,
  input  logic [31:0] EXMEM_alu_i,
  input  logic        EXMEM_alu_do_branch_i,
  input  logic [31:0] EXMEM_b_i,
  input  logic [4:0]  EXMEM_reg_write_address_i,
  input  logic        EXMEM_ctrl_branch_i,
  input  logic [1:0]  EXMEM_ctrl_mem_read_i,
  input  logic [1:0]  EXMEM_ctrl_mem_write_i,
  input  logic        EXMEM_ctrl_reg_write_i,
  input  logic        EXMEM_ctrl_mem_to_reg_i,
  output logic        MEM_do_branch_o,
  output logic [31:0] MEM_pc_branched_o,
  output logic        MEM_stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ack_i,
  output logic [31:0] MEMWB_read_data_o,
  output logic [31:0] MEMWB_alu_o,
  output logic [4:0]  MEMWB_reg_write_address_o,
  output logic        MEMWB_ctrl_reg_write_o,
  output logic        MEMWB_ctrl_mem_to_reg_o,
  output logic        misalign_o,
  output logic        bus_err_o
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state, state_nx;
  logic [15:0] cnt;
  logic [31:0] rdata_q, wdata_nx, load_data;
  logic [3:0]  be_nx;
  logic [1:0]  size;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic        is_wr, mem_op, misaligned, go, tmo_hit;
  assign is_wr      = |EXMEM_ctrl_mem_write_i;
  assign size       = is_wr ? EXMEM_ctrl_mem_write_i : EXMEM_ctrl_mem_read_i;
  assign mem_op     = |size;
  assign misaligned = (size == 2'b10 & EXMEM_alu_i[0]) | (size == 2'b11 & |EXMEM_alu_i[1:0]);
  assign go         = state == IDLE & mem_op & ~misaligned;
  assign tmo_hit    = cnt == 16'(BUS_TIMEOUT - 1);
  assign MEM_do_branch_o   = EXMEM_ctrl_branch_i & EXMEM_alu_do_branch_i;
  assign MEM_pc_branched_o = EXMEM_pc_branched_i;
  assign be_nx    = ~is_wr ? 4'b0000 : size == 2'b01 ? 4'b0001 << EXMEM_alu_i[1:0] :
                    size == 2'b10 ? (EXMEM_alu_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wdata_nx = ~is_wr ? 32'h0 : size == 2'b01 ? {4{EXMEM_b_i[7:0]}} :
                    size == 2'b10 ? {2{EXMEM_b_i[15:0]}} : EXMEM_b_i;
  assign lb        = 8'(rdata_q >> {EXMEM_alu_i[1:0], 3'b000});
  assign lh        = EXMEM_alu_i[1] ? rdata_q[31:16] : rdata_q[15:0];
  assign load_data = size == 2'b01 ? {{24{lb[7]}}, lb} : size == 2'b10 ? {{16{lh[15]}}, lh} : rdata_q;
  always_ff @(posedge clk_i)
    if (rst_i) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (go ? REQ : IDLE) :
               state == REQ ? ((dmem_ack_i | tmo_hit) ? DONE : REQ) : IDLE;
  always_comb
    MEM_stall_o = go | state == REQ;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_be_o    <= '0;
      dmem_wdata_o <= '0;
      cnt          <= '0;
      rdata_q      <= '0;
      bus_err_o    <= 1'b0;
      misalign_o   <= 1'b0;
    end else begin
      misalign_o <= state == IDLE & mem_op & misaligned;
      if (go) begin
        dmem_req_o   <= 1'b1;
        dmem_we_o    <= is_wr;
        dmem_addr_o  <= {EXMEM_alu_i[31:2], 2'b00};
        dmem_be_o    <= be_nx;
        dmem_wdata_o <= wdata_nx;
        cnt          <= '0;
      end else if (state == REQ) begin
        if (dmem_ack_i) begin
          dmem_req_o <= 1'b0;
          rdata_q    <= dmem_rdata_i;
        end else if (tmo_hit) begin
          dmem_req_o <= 1'b0;
          rdata_q    <= '0;
          bus_err_o  <= 1'b1;
        end else cnt <= cnt + 16'd1;
      end
    end
  always_ff @(posedge clk_i)
    if (rst_i | MEM_stall_o) begin
      MEMWB_read_data_o         <= '0;
      MEMWB_alu_o               <= '0;
      MEMWB_reg_write_address_o <= '0;
      MEMWB_ctrl_reg_write_o    <= 1'b0;
      MEMWB_ctrl_mem_to_reg_o   <= 1'b0;
    end else begin
      MEMWB_read_data_o         <= load_data;
      MEMWB_alu_o               <= EXMEM_alu_i;
      MEMWB_reg_write_address_o <= EXMEM_reg_write_address_i;
      MEMWB_ctrl_reg_write_o    <= EXMEM_ctrl_reg_write_i & ~(mem_op & misaligned);
      MEMWB_ctrl_mem_to_reg_o   <= EXMEM_ctrl_mem_to_reg_i & ~(mem_op & misaligned);
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed + random check of mem_stage against a transaction-level model
module tb_mem_stage;
  localparam int T = 4;
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] pc_br, alu, b, rdata, memwb_rd, memwb_alu, addr, wdata, pc_out;
  logic        alu_br, ctrl_br, rw, m2r, do_br, stall, req, we, ack, memwb_rw, memwb_m2r, mis, berr;
  logic [4:0]  ra, memwb_ra;
  logic [1:0]  mrd, mwr;
  logic [3:0]  be;
  int          total = 0, bad = 0;
  logic        err_m = 1'b0;
  always #5 clk = ~clk;
  mem_stage #(.BUS_TIMEOUT(T)) dut (
    .clk_i(clk), .rst_i(rst),
    .EXMEM_pc_branched_i(pc_br), .EXMEM_alu_i(alu), .EXMEM_alu_do_branch_i(alu_br),
    .EXMEM_b_i(b), .EXMEM_reg_write_address_i(ra), .EXMEM_ctrl_branch_i(ctrl_br),
    .EXMEM_ctrl_mem_read_i(mrd), .EXMEM_ctrl_mem_write_i(mwr),
    .EXMEM_ctrl_reg_write_i(rw), .EXMEM_ctrl_mem_to_reg_i(m2r),
    .MEM_do_branch_o(do_br), .MEM_pc_branched_o(pc_out), .MEM_stall_o(stall),
    .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(addr), .dmem_be_o(be),
    .dmem_wdata_o(wdata), .dmem_rdata_i(rdata), .dmem_ack_i(ack),
    .MEMWB_read_data_o(memwb_rd), .MEMWB_alu_o(memwb_alu),
    .MEMWB_reg_write_address_o(memwb_ra), .MEMWB_ctrl_reg_write_o(memwb_rw),
    .MEMWB_ctrl_mem_to_reg_o(memwb_m2r), .misalign_o(mis), .bus_err_o(berr)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chkb(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic nop();
    {pc_br, alu, b, rdata} = '0;
    {alu_br, ctrl_br, rw, m2r, ack} = '0;
    ra = '0; mrd = '0; mwr = '0;
  endtask
  task automatic run_op(input logic [1:0] rd_op, wr_op, input logic [31:0] a, bv, rd_word,
                        input int waits, input logic [4:0] dst, input logic rwv, m2rv);
    logic        is_wr, mis_m, tmo;
    logic [1:0]  sz;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, exp_rd, w;
    int          n_req;
    is_wr = wr_op != 2'b00;
    sz    = is_wr ? wr_op : rd_op;
    mis_m = (sz == 2'd2 && a % 2 != 0) || (sz == 2'd3 && a % 4 != 0);
    nop();
    mrd = rd_op; mwr = wr_op; alu = a; b = bv; ra = dst; rw = rwv; m2r = m2rv;
    #1;
    chkb("stall_at_issue", stall, sz != 2'd0 && !mis_m);
    if (sz == 2'd0) begin
      cyc();
      chkb("alu_req", req, 1'b0);
      chkb("alu_wb_rw", memwb_rw, rwv);
      chkb("alu_wb_m2r", memwb_m2r, m2rv);
      chk("alu_wb_alu", memwb_alu, a);
      chk("alu_wb_ra", 32'(memwb_ra), 32'(dst));
      return;
    end
    if (mis_m) begin
      cyc();
      chkb("mis_pulse", mis, 1'b1);
      chkb("mis_req", req, 1'b0);
      chkb("mis_wb_rw", memwb_rw, 1'b0);
      chkb("mis_wb_m2r", memwb_m2r, 1'b0);
      nop();
      cyc();
      chkb("mis_pulse_end", mis, 1'b0);
      return;
    end
    exp_be = 4'b0000;
    exp_wd = 32'h0;
    if (is_wr) begin
      if (sz == 2'd1) begin exp_be[a % 4] = 1'b1; exp_wd = bv[7:0] * 32'h0101_0101; end
      else if (sz == 2'd2) begin exp_be = (a % 4 >= 2) ? 4'hC : 4'h3; exp_wd = bv[15:0] * 32'h0001_0001; end
      else begin exp_be = 4'hF; exp_wd = bv; end
    end
    cyc();
    chkb("req_up", req, 1'b1);
    chkb("req_we", we, is_wr);
    chk("req_addr", addr, a - a % 4);
    chk("req_be", 32'(be), 32'(exp_be));
    if (is_wr) chk("req_wdata", wdata, exp_wd);
    chkb("req_bubble", memwb_rw, 1'b0);
    tmo   = waits >= T;
    n_req = tmo ? T : waits + 1;
    for (int k = 0; k < n_req; k++) begin
      ack   = (k == waits);
      rdata = ack ? rd_word : $urandom;
      #1;
      chkb("wait_stall", stall, 1'b1);
      chkb("wait_req", req, 1'b1);
      chk("wait_addr", addr, a - a % 4);
      cyc();
    end
    ack = 1'b0;
    rdata = $urandom;
    err_m = err_m | tmo;
    #1;
    chkb("done_stall", stall, 1'b0);
    chkb("done_req", req, 1'b0);
    chkb("bus_err", berr, err_m);
    if (!is_wr) begin
      w = tmo ? 32'h0 : rd_word;
      if (sz == 2'd1) begin w = w >> (8 * (a % 4)); exp_rd = 32'($signed(w[7:0])); end
      else if (sz == 2'd2) begin w = w >> ((a % 4 >= 2) ? 16 : 0); exp_rd = 32'($signed(w[15:0])); end
      else exp_rd = w;
    end else exp_rd = 32'h0;
    cyc();
    chkb("wb_rw", memwb_rw, rwv);
    chkb("wb_m2r", memwb_m2r, m2rv);
    chk("wb_alu", memwb_alu, a);
    chk("wb_ra", 32'(memwb_ra), 32'(dst));
    if (!is_wr) chk("wb_rdata", memwb_rd, exp_rd);
  endtask
  initial begin
    nop();
    rst = 1'b1;
    cyc();
    cyc();
    chkb("rst_req", req, 1'b0);
    chkb("rst_mis", mis, 1'b0);
    chkb("rst_berr", berr, 1'b0);
    chkb("rst_wb_rw", memwb_rw, 1'b0);
    chk("rst_wb_rd", memwb_rd, 32'h0);
    chk("rst_addr", addr, 32'h0);
    chkb("rst_stall", stall, 1'b0);
    rst = 1'b0;
    run_op(2'd0, 2'd0, 32'h1234, 32'h0, 32'h0, 0, 5'd5, 1'b1, 1'b0);
    chk("alu_result", memwb_alu, 32'h1234);
    run_op(2'd1, 2'd0, 32'h103, 32'h0, 32'h80FF_FF00, 0, 5'd7, 1'b1, 1'b1);
    chk("lb_result", memwb_rd, 32'hFFFF_FF80);
    run_op(2'd0, 2'd2, 32'h202, 32'hAAAA_BEEF, 32'h0, 3, 5'd0, 1'b0, 1'b0);
    run_op(2'd3, 2'd0, 32'h6, 32'h0, 32'h0, 0, 5'd3, 1'b1, 1'b1);
    run_op(2'd3, 2'd0, 32'h40, 32'h0, 32'h0, 10, 5'd9, 1'b1, 1'b1);
    chkb("tmo_berr", berr, 1'b1);
    chk("tmo_rdata", memwb_rd, 32'h0);
    run_op(2'd0, 2'd0, 32'h55, 32'h0, 32'h0, 0, 5'd1, 1'b1, 1'b0);
    chkb("berr_sticky", berr, 1'b1);
    nop();
    ctrl_br = 1'b1; alu_br = 1'b1; pc_br = 32'h40;
    #1;
    chkb("br_taken", do_br, 1'b1);
    chk("br_target", pc_out, 32'h40);
    for (int i = 0; i < 8; i++) begin
      ctrl_br = 1'($urandom); alu_br = 1'($urandom); pc_br = $urandom;
      #1;
      chkb("br_rand", do_br, ctrl_br & alu_br);
      chk("br_rand_pc", pc_out, pc_br);
    end
    cyc();
    for (int i = 0; i < 150; i++)
      run_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
             int'($urandom_range(0, 5)), 5'($urandom), 1'($urandom), 1'($urandom));
    nop();
    mrd = 2'd3; alu = 32'h80; rw = 1'b1;
    cyc();
    chkb("mid_req", req, 1'b1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    nop();
    chkb("mid_rst_req", req, 1'b0);
    chkb("mid_rst_berr", berr, 1'b0);
    chkb("mid_rst_wb_rw", memwb_rw, 1'b0);
    chk("mid_rst_addr", addr, 32'h0);
    ack = 1'b1; rdata = 32'hFFFF_FFFF;
    #1;
    chkb("late_ack_stall", stall, 1'b0);
    cyc();
    ack = 1'b0;
    #1;
    chkb("late_ack_req", req, 1'b0);
    chk("late_ack_rd", memwb_rd, 32'h0);
    chkb("late_ack_stall2", stall, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
